// File: rtl/pll_seq_pkg.sv
// Shared state encodings, default parameters and helpers for the PLL reset sequencer.
package pll_seq_pkg;

    // FSM state encodings
    localparam logic [2:0] PLL_RST   = 3'd0;
    localparam logic [2:0] WAIT_LOCK = 3'd1;
    localparam logic [2:0] STABLE    = 3'd2;
    localparam logic [2:0] RUN       = 3'd3;
    localparam logic [2:0] FAULT     = 3'd4;

    // Default timing for a 50 MHz refclk
    localparam int unsigned DEF_SYNC_STAGES    = 2;
    localparam int unsigned DEF_PLL_RST_CYCLES = 50;
    localparam int unsigned DEF_LOCK_TIMEOUT   = 50000;
    localparam int unsigned DEF_LOCK_STABLE    = 1000;
    localparam int unsigned DEF_MAX_RETRIES    = 4;
    localparam int unsigned DEF_CNT_W          = 16;

    // 3-bit increment that sticks at 7
    function automatic logic [2:0] sat_inc3(input logic [2:0] v);
        return (v == 3'd7) ? v : v + 3'd1;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for a single asynchronous bit, with synchronous active-low clear.
module sync_bit #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    if (STAGES < 1) begin : g_bad_stages
        $error("sync_bit: STAGES must be at least 1");
    end

    logic [STAGES-1:0] sync_q;

    if (STAGES == 1) begin : g_single
        // Single flop: capture the input directly
        always_ff @(posedge clk) begin
            if (!rst_n) sync_q <= 1'b0;
            else        sync_q <= d;
        end
    end else begin : g_chain
        // Shift the input through the flop chain
        always_ff @(posedge clk) begin
            if (!rst_n) sync_q <= '0;
            else        sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset controller: pulses the PLL reset, qualifies lock with a timeout, retry and
// stability window, and only then releases the downstream synchronous reset.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int unsigned PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
    parameter int unsigned LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
    parameter int unsigned LOCK_STABLE    = DEF_LOCK_STABLE,
    parameter int unsigned MAX_RETRIES    = DEF_MAX_RETRIES,
    parameter int unsigned CNT_W          = DEF_CNT_W
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       pll_activeclk,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       fault,
    output logic [2:0] retry_count,
    output logic       clk_switch,
    output logic       clk_sw_seen
);

    if (MAX_RETRIES > 7 || MAX_RETRIES == 0) begin : g_bad_retries
        $error("pll_reset_sequencer: MAX_RETRIES must be in 1..7");
    end
    if (PLL_RST_CYCLES == 0 || LOCK_TIMEOUT == 0 || LOCK_STABLE == 0) begin : g_bad_zero
        $error("pll_reset_sequencer: cycle counts must be non-zero");
    end
    if (CNT_W < 32 && (((LOCK_TIMEOUT - 1) >> CNT_W) != 0 ||
                       ((LOCK_STABLE - 1) >> CNT_W) != 0 ||
                       ((PLL_RST_CYCLES - 1) >> CNT_W) != 0)) begin : g_bad_cnt_w
        $error("pll_reset_sequencer: CNT_W too narrow for the configured cycle counts");
    end

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [2:0]       RETRY_LIMIT  = 3'(MAX_RETRIES);

    logic locked_s;
    logic active_s;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_sync_locked (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (locked_s)
    );

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_sync_active (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (pll_activeclk),
        .q     (active_s)
    );

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       retry_q, retry_d;
    logic             active_prev_q;
    logic             pll_rst_q, pll_rst_d;
    logic             sys_rst_n_q, sys_rst_n_d;
    logic             ready_q, ready_d;
    logic             fault_q, fault_d;
    logic             clk_switch_q, clk_switch_d;
    logic             clk_sw_seen_q, clk_sw_seen_d;

    // Next state and retry bookkeeping
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        case (state_q)
            PLL_RST: begin
                if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                // Lock seen on the timeout cycle wins over the retry
                if (locked_s) begin
                    state_d = STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    retry_d = sat_inc3(retry_q);
                    state_d = (retry_d == RETRY_LIMIT) ? FAULT : PLL_RST;
                end
            end
            STABLE: begin
                if (!locked_s)                state_d = WAIT_LOCK;
                else if (cnt_q == STABLE_LAST) state_d = RUN;
            end
            RUN: begin
                if (!locked_s) state_d = PLL_RST;
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = PLL_RST;
            end
        endcase
        if (state_d == RUN) retry_d = '0;
    end

    // Shared counter: cleared on any state change, idle outside the timed states
    always_comb begin
        cnt_d = '0;
        if (state_d == state_q &&
            (state_q == PLL_RST || state_q == WAIT_LOCK || state_q == STABLE)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Output next values, decoded from the next state so outputs are registered
    always_comb begin
        pll_rst_d     = (state_d == PLL_RST) || (state_d == FAULT);
        sys_rst_n_d   = (state_d == RUN);
        ready_d       = (state_d == RUN);
        fault_d       = (state_d == FAULT);
        clk_switch_d  = active_s ^ active_prev_q;
        clk_sw_seen_d = clk_sw_seen_q | clk_switch_d;
    end

    // State, counter and output registers with synchronous reset
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state_q       <= PLL_RST;
            cnt_q         <= '0;
            retry_q       <= '0;
            active_prev_q <= 1'b0;
            pll_rst_q     <= 1'b1;
            sys_rst_n_q   <= 1'b0;
            ready_q       <= 1'b0;
            fault_q       <= 1'b0;
            clk_switch_q  <= 1'b0;
            clk_sw_seen_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            retry_q       <= retry_d;
            active_prev_q <= active_s;
            pll_rst_q     <= pll_rst_d;
            sys_rst_n_q   <= sys_rst_n_d;
            ready_q       <= ready_d;
            fault_q       <= fault_d;
            clk_switch_q  <= clk_switch_d;
            clk_sw_seen_q <= clk_sw_seen_d;
        end
    end

    assign pll_rst     = pll_rst_q;
    assign sys_rst_n   = sys_rst_n_q;
    assign ready       = ready_q;
    assign fault       = fault_q;
    assign retry_count = retry_q;
    assign clk_switch  = clk_switch_q;
    assign clk_sw_seen = clk_sw_seen_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: expected output values are queued per edge
// when stimulus is planned and compared on the following falling edge.
module tb_pll_reset_sequencer;

    logic       refclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       pll_activeclk = 1'b0;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       ready;
    logic       fault;
    logic [2:0] retry_count;
    logic       clk_switch;
    logic       clk_sw_seen;

    pll_reset_sequencer #(
        .SYNC_STAGES    (2),
        .PLL_RST_CYCLES (4),
        .LOCK_TIMEOUT   (20),
        .LOCK_STABLE    (8),
        .MAX_RETRIES    (2),
        .CNT_W          (16)
    ) dut (
        .refclk        (refclk),
        .rst_n         (rst_n),
        .pll_locked    (pll_locked),
        .pll_activeclk (pll_activeclk),
        .pll_rst       (pll_rst),
        .sys_rst_n     (sys_rst_n),
        .ready         (ready),
        .fault         (fault),
        .retry_count   (retry_count),
        .clk_switch    (clk_switch),
        .clk_sw_seen   (clk_sw_seen)
    );

    always #10 refclk = ~refclk;

    // Bit positions in the observed vector
    localparam logic [8:0] M_PLL  = 9'h100;
    localparam logic [8:0] M_SYS  = 9'h080;
    localparam logic [8:0] M_RDY  = 9'h040;
    localparam logic [8:0] M_FLT  = 9'h020;
    localparam logic [8:0] M_RET  = 9'h01C;
    localparam logic [8:0] M_SW   = 9'h002;
    localparam logic [8:0] M_SEEN = 9'h001;
    localparam logic [8:0] M_ALL  = 9'h1FF;
    localparam logic [8:0] R1     = 9'h004;
    localparam logic [8:0] R2     = 9'h008;
    localparam logic [8:0] V_RST  = 9'h100;

    logic [8:0] obs;
    assign obs = {pll_rst, sys_rst_n, ready, fault, retry_count, clk_switch, clk_sw_seen};

    typedef struct {
        int unsigned cyc;
        string       tag;
        logic [8:0]  mask;
        logic [8:0]  val;
    } exp_t;

    exp_t        sb[$];
    int unsigned edge_cnt = 0;
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;

    always @(posedge refclk) edge_cnt <= edge_cnt + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    endtask

    task automatic exp_at(input int unsigned cyc, input string tag, input logic [8:0] mask,
                          input logic [8:0] val);
        exp_t e;
        e.cyc  = cyc;
        e.tag  = tag;
        e.mask = mask;
        e.val  = val;
        sb.push_back(e);
    endtask

    // Values after edge N are compared on the falling edge that follows it
    always @(negedge refclk) begin
        while (sb.size() > 0 && sb[0].cyc <= edge_cnt) begin
            exp_t e;
            e = sb.pop_front();
            check_val(e.tag, {23'b0, obs & e.mask}, {23'b0, e.val & e.mask});
        end
    end

    // Advance to just after edge e
    task automatic at_edge(input int unsigned e);
        int unsigned n = 0;
        while (edge_cnt < e && n < 10000) begin
            @(posedge refclk);
            #1;
            n++;
        end
        if (edge_cnt != e) check_val("at_edge", edge_cnt, e);
    endtask

    // Hold reset for two edges; base is the last edge that samples rst_n low
    task automatic do_reset(output int unsigned base);
        rst_n         = 1'b0;
        pll_locked    = 1'b0;
        pll_activeclk = 1'b0;
        @(posedge refclk);
        #1;
        @(posedge refclk);
        #1;
        base  = edge_cnt;
        rst_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int unsigned b;
        int unsigned t;
        int unsigned u;
        int unsigned n;

        // Lock, lock loss in RUN with relock, then an activeclk toggle
        do_reset(b);
        t = b + 30;
        u = t + 24;
        exp_at(b,      "s1_reset",        M_ALL, V_RST);
        exp_at(b + 3,  "s1_pllrst_hold",  M_PLL, M_PLL);
        exp_at(b + 4,  "s1_pllrst_rel",   M_PLL | M_SYS, 9'h000);
        exp_at(b + 20, "s1_not_ready",    M_RDY | M_SYS, 9'h000);
        exp_at(b + 21, "s1_ready",        M_RDY | M_SYS | M_RET | M_FLT, M_RDY | M_SYS);
        exp_at(t + 2,  "s4_still_run",    M_RDY | M_SYS, M_RDY | M_SYS);
        exp_at(t + 3,  "s4_drop",         M_RDY | M_SYS | M_PLL, M_PLL);
        exp_at(t + 6,  "s4_pllrst_hold",  M_PLL, M_PLL);
        exp_at(t + 7,  "s4_pllrst_rel",   M_PLL, 9'h000);
        exp_at(t + 15, "s4_relock_wait",  M_RDY, 9'h000);
        exp_at(t + 16, "s4_relock_run",   M_RDY | M_SYS | M_RET, M_RDY | M_SYS);
        exp_at(u + 2,  "s6_pre",          M_SW | M_SEEN, 9'h000);
        exp_at(u + 3,  "s6_pulse",        M_SW | M_SEEN | M_RDY, M_SW | M_SEEN | M_RDY);
        exp_at(u + 4,  "s6_pulse_end",    M_SW | M_SEEN | M_RDY, M_SEEN | M_RDY);
        exp_at(u + 10, "s6_sticky",       M_SW | M_SEEN | M_RDY, M_SEEN | M_RDY);
        at_edge(b + 10); pll_locked = 1'b1;
        at_edge(t);      pll_locked = 1'b0;
        at_edge(t + 5);  pll_locked = 1'b1;
        at_edge(u);      pll_activeclk = 1'b1;
        at_edge(u + 12); pll_activeclk = 1'b0;
        at_edge(u + 20);

        // One-cycle lock glitch inside the stability window
        do_reset(b);
        exp_at(b + 21, "s3_glitch_noready", M_RDY, 9'h000);
        exp_at(b + 22, "s3_no_retry",       M_RET, 9'h000);
        exp_at(b + 28, "s3_late_wait",      M_RDY, 9'h000);
        exp_at(b + 29, "s3_ready",          M_RDY | M_SYS | M_RET, M_RDY | M_SYS);
        at_edge(b + 10); pll_locked = 1'b1;
        at_edge(b + 17); pll_locked = 1'b0;
        at_edge(b + 18); pll_locked = 1'b1;
        at_edge(b + 35);

        // No lock ever: two retries then terminal FAULT
        do_reset(b);
        exp_at(b + 4,  "s2_wait",        M_PLL, 9'h000);
        exp_at(b + 23, "s2_pre_timeout", M_PLL | M_RET, 9'h000);
        exp_at(b + 24, "s2_retry1",      M_PLL | M_RET | M_SYS, M_PLL | R1);
        exp_at(b + 27, "s2_pulse1_hold", M_PLL, M_PLL);
        exp_at(b + 28, "s2_pulse1_rel",  M_PLL | M_RET, R1);
        exp_at(b + 47, "s2_pre_fault",   M_PLL | M_FLT, 9'h000);
        exp_at(b + 48, "s2_fault",       M_ALL, M_PLL | M_FLT | R2);
        exp_at(b + 60, "s2_terminal",    M_PLL | M_FLT | M_RDY | M_RET, M_PLL | M_FLT | R2);
        at_edge(b + 50); pll_locked = 1'b1;
        at_edge(b + 61);

        // Reset out of FAULT, then a one-cycle reset in the second WAIT_LOCK
        do_reset(b);
        exp_at(b,      "s5_reset_from_fault", M_ALL, V_RST);
        exp_at(b + 24, "s5_retry1",           M_RET, R1);
        exp_at(b + 32, "s5_mid_wait",         M_PLL | M_RET, R1);
        exp_at(b + 33, "s5_reset_mid",        M_ALL, V_RST);
        exp_at(b + 36, "s5_restart_hold",     M_PLL, M_PLL);
        exp_at(b + 37, "s5_restart_rel",      M_PLL, 9'h000);
        at_edge(b + 32); rst_n = 1'b0;
        at_edge(b + 33); rst_n = 1'b1;
        at_edge(b + 40);

        // Synced lock arriving exactly on the timeout cycle counts as lock
        do_reset(b);
        exp_at(b + 24, "s7_lock_on_timeout", M_PLL | M_RET, 9'h000);
        exp_at(b + 31, "s7_not_ready",       M_RDY, 9'h000);
        exp_at(b + 32, "s7_ready",           M_RDY | M_RET, M_RDY);
        at_edge(b + 21); pll_locked = 1'b1;
        at_edge(b + 35);

        n = 0;
        while (sb.size() > 0 && n < 100) begin
            @(posedge refclk);
            #1;
            n++;
        end
        check_val("sb_drain", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
